mem_port_arbiter: RTL and testbench

- Shares one single-port unified memory between the fetch stage (instruction reads) and the memory stage (data loads and stores).
- Sits between the pipeline stages and the memory model. It runs one transaction at a time through a request/grant/response handshake.
- Data gets priority, with a starvation guard so fetch is not locked out.
- It discards fetch responses that a taken branch or jump has made stale.

---
 rtl/mem_port_arbiter.sv | 129 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port memory between instruction fetch and the data
//   stage. One transaction is in flight at a time: IDLE -> REQ (mem_req_o
//   held until mem_gnt_i) -> RESP (waiting for mem_rvalid_i). A new winner is
//   picked in IDLE or on the edge that carries the response, so back-to-back
//   traffic runs at one transaction every two cycles.
//   Data has priority; d_streak counts data wins taken while fetch was
//   waiting, and once it reaches MAX_D_STREAK fetch wins the next
//   arbitration. A flush while fetch owns the port kills the fetch
//   handshake (gnt/rvalid) but lets the memory transaction finish.
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   if_*                fetch read request / grant / response
//   dm_*                data load/store request / grant / response
//   flush_i             taken branch/jump; makes in-flight fetch stale
//   mem_*_o / mem_*_i   registered request to memory, grant/response back
//   busy_o              a transaction is in progress
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MAX_D_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [DATA_W-1:0] if_rdata_o,
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic              dm_gnt_o,
    output logic              dm_rvalid_o,
    output logic [DATA_W-1:0] dm_rdata_o,
    input  logic              flush_i,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              busy_o
);
    localparam int SW = $clog2(MAX_D_STREAK + 1);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
    typedef enum logic {OWN_D, OWN_F} owner_t;

    state_t        state, state_nxt;
    owner_t        owner;
    logic [SW-1:0] d_streak;
    logic          drop;

    logic f_elig, arb, f_win, d_win, kill, drop_eff;

    always_comb begin
        f_elig   = if_req_i & ~flush_i;
        arb      = (state == IDLE) | ((state == RESP) & mem_rvalid_i);
        // Fetch wins when data is absent, or when data has used up its streak.
        f_win    = f_elig & (~dm_req_i | (d_streak == SW'(MAX_D_STREAK)));
        d_win    = dm_req_i & ~f_win;
        // Flush acts in the same cycle so a coincident grant/response is hidden.
        kill     = flush_i & (owner == OWN_F) & (state != IDLE);
        drop_eff = drop | kill;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (f_win | d_win) state_nxt = REQ;
            REQ:     if (mem_gnt_i) state_nxt = RESP;
            RESP:    if (mem_rvalid_i) state_nxt = (f_win | d_win) ? REQ : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        if_gnt_o    = (state == REQ)  & (owner == OWN_F) & mem_gnt_i & ~drop_eff;
        dm_gnt_o    = (state == REQ)  & (owner == OWN_D) & mem_gnt_i;
        if_rvalid_o = (state == RESP) & (owner == OWN_F) & mem_rvalid_i & ~drop_eff;
        dm_rvalid_o = (state == RESP) & (owner == OWN_D) & mem_rvalid_i;
        if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
        dm_rdata_o  = dm_rvalid_o ? mem_rdata_i : '0;
        busy_o      = (state != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            owner       <= OWN_D;
            d_streak    <= '0;
            drop        <= 1'b0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
        end else begin
            state <= state_nxt;
            if (arb) begin
                drop <= 1'b0;
                if (f_win) begin
                    owner       <= OWN_F;
                    mem_req_o   <= 1'b1;
                    mem_we_o    <= 1'b0;
                    mem_addr_o  <= if_addr_i;
                    mem_wdata_o <= '0;
                    d_streak    <= '0;
                end else if (d_win) begin
                    owner       <= OWN_D;
                    mem_req_o   <= 1'b1;
                    mem_we_o    <= dm_we_i;
                    mem_addr_o  <= dm_addr_i;
                    mem_wdata_o <= dm_wdata_i;
                    // Only wins taken at fetch's expense count toward the streak.
                    d_streak    <= f_elig ? d_streak + SW'(1) : '0;
                end else begin
                    mem_req_o <= 1'b0;
                end
            end else begin
                if ((state == REQ) && mem_gnt_i) mem_req_o <= 1'b0;
                if (kill) drop <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a per-cycle vector table from reset, directed
// sequences for reset/starvation/store/flush, then random traffic against a
// transaction-level model (reference memory, one outstanding per requester).
module tb_mem_port_arbiter;
    localparam int MAXS = 4;

    logic        clk = 1'b0, rst_n;
    logic        if_req_i, if_gnt_o, if_rvalid_o;
    logic [31:0] if_addr_i, if_rdata_o;
    logic        dm_req_i, dm_we_i, dm_gnt_o, dm_rvalid_o;
    logic [31:0] dm_addr_i, dm_wdata_i, dm_rdata_o;
    logic        flush_i, mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i, busy_o;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_D_STREAK(MAXS)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
        .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
        .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i),
        .dm_wdata_i(dm_wdata_i), .dm_gnt_o(dm_gnt_o), .dm_rvalid_o(dm_rvalid_o),
        .dm_rdata_o(dm_rdata_o), .flush_i(flush_i),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i(mem_rdata_i), .busy_o(busy_o)
    );

    int n_chk = 0, n_pass = 0;

    task automatic chkv(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask
    task automatic chk_true(input string nm, input logic c);
        chkv(nm, 256'(c), 256'(1));
    endtask

    // ---------------- memory device model ----------------
    logic [31:0] dev_mem [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];
    bit          auto_mem, rnd_mem, dv_busy;
    int          gnt_dly, rv_dly, gwait, dv_cnt;
    logic [31:0] dv_rdata;

    function automatic logic [31:0] dev_rd(input logic [31:0] a);
        return dev_mem.exists(a) ? dev_mem[a] : (a ^ 32'h5A5A_0000);
    endfunction
    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : (a ^ 32'h5A5A_0000);
    endfunction

    task automatic dev_reset();
        dv_busy = 0; dv_cnt = 0; gwait = 0;
        mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0;
    endtask

    task automatic dev_drive();
        mem_gnt_i = mem_req_o && (gwait >= gnt_dly);
        if (dv_busy && dv_cnt == 0) begin
            mem_rvalid_i = 1; mem_rdata_i = dv_rdata;
        end else begin
            mem_rvalid_i = 0; mem_rdata_i = $urandom;
            if (dv_busy) dv_cnt--;
        end
    endtask

    task automatic dev_sample();
        if (mem_rvalid_i) dv_busy = 0;
        if (mem_req_o && mem_gnt_i) begin
            if (mem_we_o) dev_mem[mem_addr_o] = mem_wdata_o;
            dv_rdata = mem_we_o ? $urandom : dev_rd(mem_addr_o);
            if (rnd_mem) begin
                rv_dly  = int'($urandom_range(0, 2));
                gnt_dly = int'($urandom_range(0, 2));
            end
            dv_busy = 1; dv_cnt = rv_dly; gwait = 0;
        end else if (mem_req_o) gwait++;
    endtask

    task automatic drv();
        @(posedge clk); #1;
        if (auto_mem) dev_drive();
    endtask
    task automatic smp();
        @(negedge clk);
        if (auto_mem) dev_sample();
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 0;
        if_req_i = 0; if_addr_i = 0; dm_req_i = 0; dm_we_i = 0;
        dm_addr_i = 0; dm_wdata_i = 0; flush_i = 0;
        dev_reset();
        @(posedge clk); #1;
        rst_n = 1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        if_req; logic [31:0] if_addr;
        logic        dm_req, dm_we; logic [31:0] dm_addr, dm_wdata;
        logic        flush, mgnt, mrv; logic [31:0] mrdata;
        logic        e_ifg, e_ifv; logic [31:0] e_ifd;
        logic        e_dg, e_dv; logic [31:0] e_dd;
        logic        e_mreq; logic [31:0] e_maddr; logic e_busy;
    } vec_t;
    vec_t vq[$];

    task automatic add_row(input logic ir, input logic [31:0] ia, input logic dr, dw,
                           input logic [31:0] da, dd, input logic fl, mg, mv,
                           input logic [31:0] md, input logic eig, eiv,
                           input logic [31:0] eid, input logic edg, edv,
                           input logic [31:0] edd, input logic emr,
                           input logic [31:0] ema, input logic eb);
        vec_t v;
        v.if_req = ir; v.if_addr = ia; v.dm_req = dr; v.dm_we = dw; v.dm_addr = da;
        v.dm_wdata = dd; v.flush = fl; v.mgnt = mg; v.mrv = mv; v.mrdata = md;
        v.e_ifg = eig; v.e_ifv = eiv; v.e_ifd = eid; v.e_dg = edg; v.e_dv = edv;
        v.e_dd = edd; v.e_mreq = emr; v.e_maddr = ema; v.e_busy = eb;
        vq.push_back(v);
    endtask

    // ---------------- random-phase model state ----------------
    bit          f_pend, f_wait, d_pend, d_wait, d_we;
    logic [31:0] f_addr, d_addr, d_wdata, f_exp, d_exp;
    int          f_run;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        bit seq[$];
        bit exp_seq[10];
        int nreq, ngnt, cyc_since;
        bit stable, done, rv_seen, mrv_seen, ok;

        rst_n = 0; auto_mem = 0; rnd_mem = 0; gnt_dly = 0; rv_dly = 0;
        do_reset();

        // ---- table: fetch+load collision, flush at an IDLE edge, flush on gnt ----
        //      ir ia       dr dw da       dd fl mg mv md            eig eiv eid          edg edv edd          emr ema      eb
        add_row(1, 32'h40, 1, 0, 32'h100, 0, 0, 1, 0, 32'hAAAA0000, 0, 0, 0,            0, 0, 0,            0, 0,       0);
        add_row(1, 32'h40, 1, 0, 32'h100, 0, 0, 1, 0, 32'hAAAA0001, 0, 0, 0,            1, 0, 0,            1, 32'h100, 1);
        add_row(1, 32'h40, 0, 0, 0,       0, 0, 1, 1, 32'h11112222, 0, 0, 0,            0, 1, 32'h11112222, 0, 0,       1);
        add_row(1, 32'h40, 0, 0, 0,       0, 0, 1, 0, 32'hBBBB0000, 1, 0, 0,            0, 0, 0,            1, 32'h40,  1);
        add_row(0, 0,      0, 0, 0,       0, 0, 1, 1, 32'h33334444, 0, 1, 32'h33334444, 0, 0, 0,            0, 0,       1);
        add_row(1, 32'h80, 0, 0, 0,       0, 1, 0, 0, 32'hCCCC0000, 0, 0, 0,            0, 0, 0,            0, 0,       0);
        add_row(1, 32'h80, 0, 0, 0,       0, 0, 0, 0, 32'hCCCC0001, 0, 0, 0,            0, 0, 0,            0, 0,       0);
        add_row(1, 32'h80, 0, 0, 0,       0, 0, 0, 0, 32'hCCCC0002, 0, 0, 0,            0, 0, 0,            1, 32'h80,  1);
        add_row(1, 32'h80, 0, 0, 0,       0, 1, 1, 0, 32'hCCCC0003, 0, 0, 0,            0, 0, 0,            1, 32'h80,  1);
        add_row(0, 0,      0, 0, 0,       0, 0, 0, 1, 32'h55556666, 0, 0, 0,            0, 0, 0,            0, 0,       1);
        add_row(0, 0,      0, 0, 0,       0, 0, 0, 0, 32'h77778888, 0, 0, 0,            0, 0, 0,            0, 0,       0);
        for (int i = 0; i < vq.size(); i++) begin
            drv();
            if_req_i = vq[i].if_req; if_addr_i = vq[i].if_addr;
            dm_req_i = vq[i].dm_req; dm_we_i = vq[i].dm_we;
            dm_addr_i = vq[i].dm_addr; dm_wdata_i = vq[i].dm_wdata;
            flush_i = vq[i].flush; mem_gnt_i = vq[i].mgnt;
            mem_rvalid_i = vq[i].mrv; mem_rdata_i = vq[i].mrdata;
            smp();
            chkv($sformatf("vec%0d", i),
                 256'({if_gnt_o, if_rvalid_o, if_rdata_o, dm_gnt_o, dm_rvalid_o, dm_rdata_o,
                       mem_req_o, (mem_req_o ? mem_addr_o : 32'h0), busy_o}),
                 256'({vq[i].e_ifg, vq[i].e_ifv, vq[i].e_ifd, vq[i].e_dg, vq[i].e_dv, vq[i].e_dd,
                       vq[i].e_mreq, vq[i].e_maddr, vq[i].e_busy}));
        end

        // ---- reset in the middle of RESP ----
        auto_mem = 1; do_reset(); gnt_dly = 0; rv_dly = 3;
        if_req_i = 1; if_addr_i = 32'h20;
        ok = 0;
        for (int c = 0; c < 10 && !ok; c++) begin drv(); smp(); ok = if_gnt_o; end
        chk_true("rst_setup_gnt", ok);
        drv(); if_req_i = 0;
        #2 rst_n = 0;
        #1 chkv("rst_outputs",
                256'({if_gnt_o, if_rvalid_o, if_rdata_o, dm_gnt_o, dm_rvalid_o, dm_rdata_o,
                      mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, busy_o}), '0);
        dev_reset();
        smp();
        drv(); rst_n = 1; if_req_i = 1; if_addr_i = 32'h44;
        smp();
        chk_true("rst_release_idle", !mem_req_o && !busy_o);
        drv(); smp();
        chkv("rst_first_req", 256'({mem_req_o, mem_addr_o}), 256'({1'b1, 32'h44}));

        // ---- starvation guard ----
        do_reset(); gnt_dly = 0; rv_dly = 0;
        if_req_i = 1; if_addr_i = 32'h10;
        dm_req_i = 1; dm_we_i = 0; dm_addr_i = 32'h104;
        exp_seq = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        for (int c = 0; c < 60 && seq.size() < 10; c++) begin
            drv(); smp();
            if (dm_gnt_o) seq.push_back(1'b0);
            if (if_gnt_o) seq.push_back(1'b1);
        end
        chk_true("starve_count", seq.size() == 10);
        for (int i = 0; i < seq.size() && i < 10; i++)
            chkv($sformatf("starve_seq%0d(1=F)", i), 256'(seq[i]), 256'(exp_seq[i]));

        // ---- store with delayed grant ----
        do_reset(); gnt_dly = 3; rv_dly = 0;
        dm_req_i = 1; dm_we_i = 1; dm_addr_i = 32'h200; dm_wdata_i = 32'hDEADBEEF;
        nreq = 0; ngnt = 0; stable = 1; done = 0;
        for (int c = 0; c < 20 && !done; c++) begin
            drv();
            if (ngnt > 0) dm_req_i = 0;
            smp();
            if (mem_req_o) begin
                nreq++;
                if ({mem_we_o, mem_addr_o, mem_wdata_o} !== {1'b1, 32'h200, 32'hDEADBEEF}) stable = 0;
            end
            if (dm_gnt_o) ngnt++;
            if (dm_rvalid_o) done = 1;
        end
        chkv("store_req_cycles", 256'(nreq), 256'(4));
        chkv("store_gnt_pulses", 256'(ngnt), 256'(1));
        chk_true("store_stable", stable);
        chk_true("store_ack", done);
        chkv("store_mem", 256'(dev_rd(32'h200)), 256'(32'hDEADBEEF));

        // ---- flush while fetch waits in RESP ----
        do_reset(); gnt_dly = 0; rv_dly = 2;
        if_req_i = 1; if_addr_i = 32'h30;
        ok = 0;
        for (int c = 0; c < 10 && !ok; c++) begin drv(); smp(); ok = if_gnt_o; end
        chk_true("flush_setup_gnt", ok);
        drv(); if_req_i = 0; flush_i = 1;
        smp(); rv_seen = if_rvalid_o; mrv_seen = mem_rvalid_i;
        cyc_since = 0;
        for (int c = 0; c < 6 && !mrv_seen; c++) begin
            drv(); flush_i = 0; smp();
            cyc_since++;
            rv_seen |= if_rvalid_o; mrv_seen = mem_rvalid_i;
        end
        chkv("flush_mem_rvalid_delay", 256'(cyc_since), 256'(2));
        chk_true("flush_no_if_rvalid", !rv_seen);
        drv(); smp();
        chk_true("flush_back_idle", !busy_o);
        rv_dly = 0; drv(); if_req_i = 1; if_addr_i = 32'h40;
        ok = 0; done = 0;
        for (int c = 0; c < 10 && !done; c++) begin
            smp();
            if (if_gnt_o) ok = 1;
            if (if_rvalid_o) begin
                done = 1;
                chkv("flush_refetch_data", 256'(if_rdata_o), 256'(32'h5A5A0040));
            end
            drv();
            if (ok) if_req_i = 0;
        end
        chk_true("flush_refetch_done", ok && done);

        // ---- random traffic vs. transaction model ----
        do_reset(); rnd_mem = 1; gnt_dly = 1; rv_dly = 1;
        dev_mem.delete(); ref_mem.delete();
        f_pend = 0; f_wait = 0; d_pend = 0; d_wait = 0; f_run = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            bit draining;
            draining = (cyc >= 3800);
            drv();
            flush_i = !draining && ($urandom_range(0, 15) == 0);
            if (!f_pend && !f_wait && !draining && $urandom_range(0, 2) == 0) begin
                f_pend = 1; f_addr = 32'($urandom_range(0, 31)) << 2; f_run = 0;
            end
            if (!d_pend && !d_wait && !draining && $urandom_range(0, 1) == 0) begin
                d_pend = 1; d_we = 1'($urandom_range(0, 1));
                d_addr = 32'($urandom_range(0, 31)) << 2; d_wdata = $urandom;
            end
            if_req_i = f_pend; if_addr_i = f_addr;
            dm_req_i = d_pend; dm_we_i = d_we; dm_addr_i = d_addr; dm_wdata_i = d_wdata;
            smp();
            chk_true("one_gnt", !(if_gnt_o && dm_gnt_o));
            if (!if_rvalid_o) chkv("if_rdata_zero", 256'(if_rdata_o), '0);
            if (!dm_rvalid_o) chkv("dm_rdata_zero", 256'(dm_rdata_o), '0);
            if (dm_gnt_o) begin
                chk_true("d_gnt_unrequested", d_pend);
                chkv("d_gnt_mem", 256'({mem_we_o, mem_addr_o, d_we ? mem_wdata_o : 32'h0}),
                     256'({d_we, d_addr, d_we ? d_wdata : 32'h0}));
                if (d_we) ref_mem[d_addr] = d_wdata;
                else d_exp = ref_rd(d_addr);
                d_pend = 0; d_wait = 1;
                if (f_pend) begin
                    f_run++;
                    chk_true("starve_bound", f_run <= MAXS + 1);
                end
            end
            if (dm_rvalid_o) begin
                chk_true("d_rv_unexpected", d_wait);
                if (!d_we) chkv("d_rdata", 256'(dm_rdata_o), 256'(d_exp));
                d_wait = 0;
            end
            if (flush_i) begin
                chk_true("flush_quiet", !if_gnt_o && !if_rvalid_o);
                f_pend = 0; f_wait = 0;
            end else begin
                if (if_gnt_o) begin
                    chk_true("f_gnt_unrequested", f_pend);
                    chkv("f_gnt_mem", 256'({mem_we_o, mem_addr_o}), 256'({1'b0, f_addr}));
                    f_exp = ref_rd(f_addr);
                    f_pend = 0; f_wait = 1; f_run = 0;
                end
                if (if_rvalid_o) begin
                    chk_true("f_rv_unexpected", f_wait);
                    chkv("f_rdata", 256'(if_rdata_o), 256'(f_exp));
                    f_wait = 0;
                end
            end
        end
        chk_true("drain_complete", !f_pend && !f_wait && !d_pend && !d_wait && !busy_o);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
